wide_byte_serializer: RTL and testbench

Parametrised wide-word-to-byte serializer feeding the PNG decoder's byte input (`istart`/`ivalid`/`iready`/`ibyte`). It accepts a packed payload word of up to `IN_BYTES` bytes with a per-word valid-byte length and a start-of-frame flag, and emits the bytes one per handshake in selectable order. Downstream backpressure is honoured. A two-slot ping-pong store lets the next word load while the current one drains, with no bubble between words.

---
 rtl/wide_byte_serializer.sv | 110 +++++++++++
 tb/tb_wide_byte_serializer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_byte_serializer.sv
// Wide-word to byte serializer with a two-slot ping-pong store, feeding a
// byte-stream decoder through a valid/ready handshake with a start pulse.
module wide_byte_serializer #(
   parameter int  IN_BYTES  = 69,
   parameter int  MSB_FIRST = 1,
   parameter int  LEN_W     = $clog2(IN_BYTES + 1),
   localparam int DATA_W    = 8 * IN_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [LEN_W-1:0]  in_len,
   input  logic              in_sof,
   output logic              out_start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              out_last,
   output logic [31:0]       byte_count
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] act_data, pend_data;
   logic [LEN_W-1:0]  act_len, act_idx, pend_len, in_len_c;
   logic              pend_valid, pend_sof;
   logic              in_fire, in_nz, out_fire, act_done, act_free;
   logic              load_act, load_sof, to_pend;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      return (l > LEN_W'(IN_BYTES)) ? LEN_W'(IN_BYTES) : l;
   endfunction

   function automatic logic [7:0] sel_byte(input logic [DATA_W-1:0] d,
                                           input logic [LEN_W-1:0]  k);
      logic [DATA_W-1:0] sh;
      if (MSB_FIRST != 0) begin
         sh = d << {k, 3'b000};
         return sh[DATA_W-1 -: 8];
      end
      sh = d >> {k, 3'b000};
      return sh[7:0];
   endfunction

   assign in_ready = !pend_valid;

   // Zero-length words are accepted but never occupy a slot.
   always_comb begin
      in_len_c = clamp_len(in_len);
      in_fire  = in_valid && !pend_valid && !rst;
      in_nz    = in_fire && (in_len_c != '0);
      out_fire = (state == S_STREAM) && out_ready;
      act_done = out_fire && (act_idx == act_len - LEN_W'(1));
      act_free = (state == S_IDLE) || act_done;
      load_act = act_free && (pend_valid || in_nz);
      load_sof = pend_valid ? pend_sof : in_sof;
      to_pend  = in_nz && !act_free;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (load_act)               state_nxt = load_sof ? S_START : S_STREAM;
      else if (act_done)          state_nxt = S_IDLE;
      else if (state == S_START)  state_nxt = S_STREAM;
   end

   always_comb begin
      out_valid = (state == S_STREAM);
      out_start = (state == S_START);
      out_last  = out_valid && (act_idx == act_len - LEN_W'(1));
      out_byte  = out_valid ? sel_byte(act_data, act_idx) : 8'h00;
   end

   // Control registers: slot occupancy, byte index, handoff counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_valid <= 1'b0;
         act_idx    <= '0;
         byte_count <= '0;
      end else begin
         if (load_act)      act_idx <= '0;
         else if (out_fire) act_idx <= act_idx + LEN_W'(1);
         if (load_act && pend_valid) pend_valid <= 1'b0;
         else if (to_pend)           pend_valid <= 1'b1;
         if (out_fire) byte_count <= byte_count + 32'd1;
      end
   end

   // Payload registers carry no reset; occupancy is tracked by control state.
   always_ff @(posedge clk) begin
      if (load_act) begin
         act_data <= pend_valid ? pend_data : in_data;
         act_len  <= pend_valid ? pend_len  : in_len_c;
      end
      if (to_pend) begin
         pend_data <= in_data;
         pend_len  <= in_len_c;
         pend_sof  <= in_sof;
      end
   end

endmodule

// File: tb/tb_wide_byte_serializer.sv
// Directed bench for wide_byte_serializer: one MSB-first and one LSB-first
// instance sharing clock and reset, checked against hand-computed bytes.
module tb_wide_byte_serializer;

   localparam int NB = 69;
   localparam int DW = 8 * NB;
   localparam int LW = 7;

   logic clk, rst;

   logic          m_in_valid, m_in_ready, m_in_sof, m_out_start, m_out_valid;
   logic          m_out_ready, m_out_last;
   logic [DW-1:0] m_in_data;
   logic [LW-1:0] m_in_len;
   logic [7:0]    m_out_byte;
   logic [31:0]   m_byte_count;

   logic          l_in_valid, l_in_ready, l_in_sof, l_out_start, l_out_valid;
   logic          l_out_ready, l_out_last;
   logic [DW-1:0] l_in_data;
   logic [LW-1:0] l_in_len;
   logic [7:0]    l_out_byte;
   logic [31:0]   l_byte_count;

   int checks   = 0;
   int failures = 0;

   wide_byte_serializer #(.IN_BYTES(NB), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .in_data(m_in_data), .in_len(m_in_len), .in_sof(m_in_sof),
      .out_start(m_out_start), .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out_byte(m_out_byte), .out_last(m_out_last), .byte_count(m_byte_count)
   );

   wide_byte_serializer #(.IN_BYTES(NB), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
      .in_data(l_in_data), .in_len(l_in_len), .in_sof(l_in_sof),
      .out_start(l_out_start), .out_valid(l_out_valid), .out_ready(l_out_ready),
      .out_byte(l_out_byte), .out_last(l_out_last), .byte_count(l_byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // MSB-first word: byte k = base+k for k < n, unused bytes filled with FF.
   function automatic logic [DW-1:0] mk_word(input logic [7:0] base, input int n);
      logic [DW-1:0] w;
      w = '1;
      for (int k = 0; k < n; k++) w[DW-1-8*k -: 8] = base + 8'(k);
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      m_in_valid = 1'b0; m_in_data = '0; m_in_len = '0; m_in_sof = 1'b0; m_out_ready = 1'b1;
      l_in_valid = 1'b0; l_in_data = '0; l_in_len = '0; l_in_sof = 1'b0; l_out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({m_out_valid, m_out_start, m_out_last, m_in_ready} !== 4'b0001) begin
         failures++;
         $display("FAIL reset_ctrl_msb got=%b exp=0001", {m_out_valid, m_out_start, m_out_last, m_in_ready});
      end
      checks++;
      if (m_out_byte !== 8'h00) begin
         failures++; $display("FAIL reset_byte_msb got=%0h exp=0", m_out_byte);
      end
      checks++;
      if (m_byte_count !== 32'd0) begin
         failures++; $display("FAIL reset_count_msb got=%0d exp=0", m_byte_count);
      end
      checks++;
      if ({l_out_valid, l_out_start, l_out_last, l_in_ready, l_out_byte, l_byte_count} !==
          {4'b0001, 8'h00, 32'd0}) begin
         failures++;
         $display("FAIL reset_lsb got=%b/%0h/%0d exp=0001/0/0",
                  {l_out_valid, l_out_start, l_out_last, l_in_ready}, l_out_byte, l_byte_count);
      end
   endtask

   task automatic test_single_sof();
      m_in_data = mk_word(8'h01, NB); m_in_len = 7'd69; m_in_sof = 1'b1;
      m_in_valid = 1'b1; m_out_ready = 1'b1;
      tick();
      m_in_valid = 1'b0;
      checks++;
      if ({m_out_start, m_out_valid} !== 2'b10) begin
         failures++; $display("FAIL sof_start got=%b exp=10", {m_out_start, m_out_valid});
      end
      tick();
      for (int k = 0; k < NB; k++) begin
         checks++;
         if ({m_out_valid, m_out_start, m_out_last, m_out_byte} !== {1'b1, 1'b0, (k == NB-1), 8'(k+1)}) begin
            failures++;
            $display("FAIL sof_byte%0d got=%b/%0h exp=1%0b/%0h", k,
                     {m_out_valid, m_out_start, m_out_last}, m_out_byte, (k == NB-1), 8'(k+1));
         end
         tick();
      end
      checks++;
      if ({m_out_valid, m_out_start} !== 2'b00) begin
         failures++; $display("FAIL sof_end got=%b exp=00", {m_out_valid, m_out_start});
      end
      checks++;
      if (m_byte_count !== 32'd69) begin
         failures++; $display("FAIL sof_count got=%0d exp=69", m_byte_count);
      end
   endtask

   task automatic test_short_lsb();
      logic [23:0] seq;
      seq = 24'hCCBBAA;
      l_in_data = '0; l_in_data[23:0] = seq; l_in_len = 7'd3; l_in_sof = 1'b0;
      l_in_valid = 1'b1; l_out_ready = 1'b1;
      tick();
      l_in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({l_out_valid, l_out_last, l_out_byte} !== {1'b1, (k == 2), seq[8*k +: 8]}) begin
            failures++;
            $display("FAIL lsb_byte%0d got=%b/%0h exp=1%0b/%0h", k,
                     {l_out_valid, l_out_last}, l_out_byte, (k == 2), seq[8*k +: 8]);
         end
         tick();
      end
      checks++;
      if ({l_out_valid, l_byte_count} !== {1'b0, 32'd3}) begin
         failures++; $display("FAIL lsb_end got=%b/%0d exp=0/3", l_out_valid, l_byte_count);
      end
      l_in_data = '1; l_in_len = 7'd0; l_in_sof = 1'b1; l_in_valid = 1'b1;
      tick();
      l_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({l_out_valid, l_out_start, l_in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL zero_len_c%0d got=%b exp=001", i, {l_out_valid, l_out_start, l_in_ready});
         end
         tick();
      end
      checks++;
      if (l_byte_count !== 32'd3) begin
         failures++; $display("FAIL zero_len_count got=%0d exp=3", l_byte_count);
      end
   endtask

   task automatic test_backpressure();
      int e;
      m_in_data = mk_word(8'h10, 5); m_in_len = 7'd5; m_in_sof = 1'b0;
      m_in_valid = 1'b1; m_out_ready = 1'b0;
      tick();
      m_in_valid = 1'b0;
      e = 0;
      for (int i = 0; i < 20 && e < 5; i++) begin
         m_out_ready = (i % 3 == 0);
         checks++;
         if ({m_out_valid, m_out_last, m_out_byte} !== {1'b1, (e == 4), 8'h10 + 8'(e)}) begin
            failures++;
            $display("FAIL bp_c%0d got=%b/%0h exp=1%0b/%0h", i,
                     {m_out_valid, m_out_last}, m_out_byte, (e == 4), 8'h10 + 8'(e));
         end
         tick();
         if (i % 3 == 0) e++;
      end
      m_out_ready = 1'b1;
      checks++;
      if ({m_out_valid, m_byte_count} !== {1'b0, 32'd74}) begin
         failures++; $display("FAIL bp_end got=%b/%0d exp=0/74", m_out_valid, m_byte_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] eb;
      logic       er;
      m_out_ready = 1'b1;
      m_in_data = mk_word(8'hA0, 4); m_in_len = 7'd4; m_in_sof = 1'b0; m_in_valid = 1'b1;
      tick();
      for (int c = 0; c < 12; c++) begin
         if (c == 0)      m_in_data = mk_word(8'hB0, 4);
         else if (c == 1) m_in_data = mk_word(8'hC0, 4);
         else if (c == 5) m_in_valid = 1'b0;
         eb = (c < 4) ? 8'hA0 + 8'(c) : (c < 8) ? 8'hB0 + 8'(c-4) : 8'hC0 + 8'(c-8);
         er = (c % 4 == 0) || (c >= 8);
         checks++;
         if ({m_out_valid, m_out_last, m_in_ready, m_out_byte} !== {1'b1, (c % 4 == 3), er, eb}) begin
            failures++;
            $display("FAIL b2b_c%0d got=%b/%0h exp=1%0b%0b/%0h", c,
                     {m_out_valid, m_out_last, m_in_ready}, m_out_byte, (c % 4 == 3), er, eb);
         end
         tick();
      end
      checks++;
      if ({m_out_valid, m_byte_count} !== {1'b0, 32'd86}) begin
         failures++; $display("FAIL b2b_end got=%b/%0d exp=0/86", m_out_valid, m_byte_count);
      end
   endtask

   task automatic test_reset_mid();
      m_out_ready = 1'b1;
      m_in_data = mk_word(8'h50, 10); m_in_len = 7'd10; m_in_sof = 1'b0; m_in_valid = 1'b1;
      tick();
      m_in_data = mk_word(8'h60, 4); m_in_len = 7'd4;
      tick();
      m_in_valid = 1'b0;
      checks++;
      if ({m_in_ready, m_out_byte} !== {1'b0, 8'h51}) begin
         failures++; $display("FAIL mid_pending got=%b/%0h exp=0/51", m_in_ready, m_out_byte);
      end
      tick();
      tick();
      checks++;
      if (m_out_byte !== 8'h53) begin
         failures++; $display("FAIL mid_byte3 got=%0h exp=53", m_out_byte);
      end
      rst = 1'b1;
      m_in_data = mk_word(8'hEE, 5); m_in_len = 7'd5; m_in_sof = 1'b1; m_in_valid = 1'b1;
      tick();
      rst = 1'b0;
      m_in_valid = 1'b0;
      checks++;
      if ({m_out_valid, m_out_start, m_out_last, m_in_ready, m_out_byte, m_byte_count} !==
          {4'b0001, 8'h00, 32'd0}) begin
         failures++;
         $display("FAIL mid_after_rst got=%b/%0h/%0d exp=0001/0/0",
                  {m_out_valid, m_out_start, m_out_last, m_in_ready}, m_out_byte, m_byte_count);
      end
      tick();
      checks++;
      if ({m_out_valid, m_out_start, m_in_ready} !== 3'b001) begin
         failures++; $display("FAIL mid_quiet got=%b exp=001", {m_out_valid, m_out_start, m_in_ready});
      end
      m_in_data = mk_word(8'h70, 3); m_in_len = 7'd3; m_in_sof = 1'b1; m_in_valid = 1'b1;
      tick();
      m_in_valid = 1'b0;
      checks++;
      if ({m_out_start, m_out_valid} !== 2'b10) begin
         failures++; $display("FAIL mid_restart got=%b exp=10", {m_out_start, m_out_valid});
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({m_out_valid, m_out_last, m_out_byte} !== {1'b1, (k == 2), 8'h70 + 8'(k)}) begin
            failures++;
            $display("FAIL mid_byte%0d got=%b/%0h exp=1%0b/%0h", k,
                     {m_out_valid, m_out_last}, m_out_byte, (k == 2), 8'h70 + 8'(k));
         end
         tick();
      end
      checks++;
      if ({m_out_valid, m_byte_count} !== {1'b0, 32'd3}) begin
         failures++; $display("FAIL mid_end got=%b/%0d exp=0/3", m_out_valid, m_byte_count);
      end
   endtask

   task automatic test_clamp();
      int n;
      m_out_ready = 1'b1;
      m_in_data = mk_word(8'h80, NB); m_in_len = 7'd100; m_in_sof = 1'b0; m_in_valid = 1'b1;
      tick();
      m_in_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 80 && m_out_valid; i++) begin
         checks++;
         if ({m_out_last, m_out_byte} !== {(n == NB-1), 8'h80 + 8'(n)}) begin
            failures++;
            $display("FAIL clamp_byte%0d got=%b/%0h exp=%0b/%0h", n,
                     m_out_last, m_out_byte, (n == NB-1), 8'h80 + 8'(n));
         end
         n++;
         tick();
      end
      checks++;
      if (n != NB) begin
         failures++; $display("FAIL clamp_len got=%0d exp=%0d", n, NB);
      end
      checks++;
      if (m_byte_count !== 32'd72) begin
         failures++; $display("FAIL clamp_count got=%0d exp=72", m_byte_count);
      end
   endtask

   initial begin
      test_reset();
      test_single_sof();
      test_short_lsb();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_clamp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
